// File: rtl/lane_pkg.sv
// Shared types and helpers for the lane packer/unpacker pair.
// idx_w gives the lane-index width, never narrower than one bit.
package lane_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } unpack_state_e;

   function automatic int idx_w(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/lane_counter.sv
// Lane index counter 0..LANES-1 with clear and increment; holds at the
// last lane so the index only returns to zero through an explicit clear.
module lane_counter
   import lane_pkg::*;
#(
   parameter int LANES = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     inc_i,
   input  logic                     clr_i,
   output logic [idx_w(LANES)-1:0]  idx_o,
   output logic                     is_last_o
);

   localparam int IDX_W = idx_w(LANES);
   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(LANES - 1);

   logic [IDX_W-1:0] cnt_q, cnt_d;

   // Clear wins over increment so a new word always starts at lane 0.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != LastIdx)) begin
         cnt_d = cnt_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign idx_o     = cnt_q;
   assign is_last_o = (cnt_q == LastIdx);

endmodule

// File: rtl/lane_unpacker.sv
// Splits a packed LANES*LANE_W word (lane 0 in the LSBs) into one lane per
// accepted output beat, with valid/ready handshakes on both sides.
module lane_unpacker
   import lane_pkg::*;
#(
   parameter int LANES  = 2,
   parameter int LANE_W = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*LANE_W-1:0]   in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANE_W-1:0]         out_data,
   output logic [idx_w(LANES)-1:0]   out_idx,
   output logic                      out_last
);

   localparam int IDX_W = idx_w(LANES);

   unpack_state_e state_q, state_d;

   logic [LANES*LANE_W-1:0] word_q, word_d;
   logic [IDX_W-1:0]        lane_idx;
   logic                    lane_is_last;
   logic                    capture;
   logic                    lane_hs;
   logic                    final_hs;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A final-lane handshake that coincides with a new word stays in EMIT,
   // which is what gives back-to-back words with no bubble.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (capture) begin
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (final_hs) begin
               state_d = capture ? EMIT : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // in_ready is held low during reset so no word is taken in that cycle.
   always_comb begin
      out_valid = (state_q == EMIT);
      lane_hs   = out_valid && out_ready;
      final_hs  = lane_hs && lane_is_last;
      in_ready  = !rst && ((state_q == IDLE) || final_hs);
      capture   = in_valid && in_ready;
      out_last  = out_valid && lane_is_last;
   end

   always_comb begin
      word_d = word_q;
      if (capture) begin
         word_d = in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '0;
      end else begin
         word_q <= word_d;
      end
   end

   lane_counter #(
      .LANES (LANES)
   ) u_lane_counter (
      .clk_i     (clk),
      .rst_i     (rst),
      .inc_i     (lane_hs && !lane_is_last),
      .clr_i     (capture || final_hs),
      .idx_o     (lane_idx),
      .is_last_o (lane_is_last)
   );

   assign out_idx  = lane_idx;
   assign out_data = word_q[LANE_W*int'(lane_idx) +: LANE_W];

endmodule

// File: tb/tb_lane_unpacker.sv
// Self-checking bench for lane_unpacker: directed scenarios on the 2x4 build
// plus random sweeps on 1x8 and 4x3 builds against a slicing scoreboard.
module tb_lane_unpacker;

   typedef struct {
      logic [7:0] data;
      logic [1:0] idx;
      logic       last;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic       inValid, inReady, outValid, outReady, outLast;
   logic [7:0] inData;
   logic [3:0] outData;
   logic [0:0] outIdx;

   logic       inValid1, inReady1, outValid1, outReady1, outLast1;
   logic [7:0] inData1, outData1;
   logic [0:0] outIdx1;

   logic        inValid4, inReady4, outValid4, outReady4, outLast4;
   logic [11:0] inData4;
   logic [2:0]  outData4;
   logic [1:0]  outIdx4;

   beat_t sb[$];
   beat_t sb1[$];
   beat_t sb4[$];

   int errors = 0;
   int checks = 0;

   lane_unpacker #(.LANES(2), .LANE_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .in_data(inData),
      .out_valid(outValid), .out_ready(outReady), .out_data(outData),
      .out_idx(outIdx), .out_last(outLast)
   );

   lane_unpacker #(.LANES(1), .LANE_W(8)) dut1 (
      .clk(clk), .rst(rst), .in_valid(inValid1), .in_ready(inReady1), .in_data(inData1),
      .out_valid(outValid1), .out_ready(outReady1), .out_data(outData1),
      .out_idx(outIdx1), .out_last(outLast1)
   );

   lane_unpacker #(.LANES(4), .LANE_W(3)) dut4 (
      .clk(clk), .rst(rst), .in_valid(inValid4), .in_ready(inReady4), .in_data(inData4),
      .out_valid(outValid4), .out_ready(outReady4), .out_data(outData4),
      .out_idx(outIdx4), .out_last(outLast4)
   );

   // Reference slicing: every accepted word becomes LANES expected beats.
   task automatic pushMain(input logic [7:0] word);
      beat_t b;
      for (int k = 0; k < 2; k++) begin
         b.data = (word >> (4*k)) & 8'h0F;
         b.idx  = 2'(k);
         b.last = (k == 1);
         sb.push_back(b);
      end
   endtask

   task automatic push1(input logic [7:0] word);
      beat_t b;
      b.data = word;
      b.idx  = 2'd0;
      b.last = 1'b1;
      sb1.push_back(b);
   endtask

   task automatic push4(input logic [11:0] word);
      beat_t b;
      logic [11:0] sh;
      for (int k = 0; k < 4; k++) begin
         sh     = (word >> (3*k)) & 12'h007;
         b.data = sh[7:0];
         b.idx  = 2'(k);
         b.last = (k == 3);
         sb4.push_back(b);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; inValid = 1'b1; inData = 8'hFF; outReady = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         checks++;
         if (outValid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", outValid);
         end
         checks++;
         if (inReady !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", inReady);
         end
      end
      @(posedge clk); #1;
      rst = 1'b0; inValid = 1'b0;
      @(negedge clk);
      checks++;
      if (inReady !== 1'b1) begin
         errors++; $display("[TB] FAIL post_reset_in_ready: got %b expected 1", inReady);
      end
      checks++;
      if ({outValid, outData, outIdx, outLast} !== 7'b0) begin
         errors++; $display("[TB] FAIL post_reset_outputs: got v=%b d=%h i=%b l=%b expected all 0",
                            outValid, outData, outIdx, outLast);
      end
      checks++;
      if ({outValid1, outLast1, outValid4, outLast4} !== 4'b0) begin
         errors++; $display("[TB] FAIL post_reset_sweep_duts: got %b expected 0000",
                            {outValid1, outLast1, outValid4, outLast4});
      end
   endtask

   task automatic test_single();
      bit sent = 0;
      beat_t exp;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         inValid = !sent; inData = 8'h5A; outReady = 1'b1;
         @(negedge clk);
         if (inValid && inReady) begin sent = 1; pushMain(inData); end
         if (outValid && outReady) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("[TB] FAIL single_beat: got unexpected lane %h idx %0d", outData, outIdx);
            end else begin
               exp = sb.pop_front();
               if ({outData, outIdx, outLast} !== {exp.data[3:0], exp.idx[0], exp.last}) begin
                  errors++; $display("[TB] FAIL single_beat: got %h/%0d/%b expected %h/%0d/%b",
                                     outData, outIdx, outLast, exp.data[3:0], exp.idx[0], exp.last);
               end
            end
         end
         if (c == 3) begin
            checks++;
            if (outValid !== 1'b0) begin
               errors++; $display("[TB] FAIL single_idle_after: got out_valid=%b expected 0", outValid);
            end
         end
      end
      checks++;
      if (sb.size() != 0 || !sent) begin
         errors++; $display("[TB] FAIL single_drain: got %0d pending sent=%0d expected 0 pending sent=1",
                            sb.size(), sent);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] words [3] = '{8'h21, 8'h43, 8'h65};
      int wi = 0;
      beat_t exp;
      for (int c = 0; c < 9; c++) begin
         @(posedge clk); #1;
         inValid = (wi < 3); inData = (wi < 3) ? words[wi] : 8'h00; outReady = 1'b1;
         @(negedge clk);
         if (inValid && inReady) begin pushMain(inData); wi++; end
         if (outValid && outReady) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("[TB] FAIL b2b_beat: got unexpected lane %h idx %0d", outData, outIdx);
            end else begin
               exp = sb.pop_front();
               if ({outData, outIdx, outLast} !== {exp.data[3:0], exp.idx[0], exp.last}) begin
                  errors++; $display("[TB] FAIL b2b_beat: got %h/%0d/%b expected %h/%0d/%b",
                                     outData, outIdx, outLast, exp.data[3:0], exp.idx[0], exp.last);
               end
            end
         end
         if (c >= 1 && c <= 6) begin
            checks++;
            if (outValid !== 1'b1) begin
               errors++; $display("[TB] FAIL b2b_no_bubble: cycle %0d got out_valid=%b expected 1", c, outValid);
            end
            checks++;
            if (inReady !== (c % 2 == 0)) begin
               errors++; $display("[TB] FAIL b2b_in_ready_pulse: cycle %0d got %b expected %b",
                                  c, inReady, (c % 2 == 0));
            end
         end
         if (c == 7) begin
            checks++;
            if (outValid !== 1'b0) begin
               errors++; $display("[TB] FAIL b2b_idle_after: got out_valid=%b expected 0", outValid);
            end
         end
      end
      checks++;
      if (sb.size() != 0 || wi != 3) begin
         errors++; $display("[TB] FAIL b2b_drain: got %0d pending, %0d words expected 0 pending, 3 words",
                            sb.size(), wi);
      end
   endtask

   task automatic test_backpressure();
      bit sent = 0;
      beat_t exp;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         inValid = !sent; inData = 8'hC3; outReady = (c >= 5);
         @(negedge clk);
         if (inValid && inReady) begin sent = 1; pushMain(inData); end
         if (outValid && outReady) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("[TB] FAIL bp_beat: got unexpected lane %h idx %0d", outData, outIdx);
            end else begin
               exp = sb.pop_front();
               if ({outData, outIdx, outLast} !== {exp.data[3:0], exp.idx[0], exp.last}) begin
                  errors++; $display("[TB] FAIL bp_beat: got %h/%0d/%b expected %h/%0d/%b",
                                     outData, outIdx, outLast, exp.data[3:0], exp.idx[0], exp.last);
               end
            end
         end
         if (c >= 1 && c <= 4) begin
            checks++;
            if ({outValid, outData, outIdx, outLast} !== {1'b1, 4'h3, 1'b0, 1'b0}) begin
               errors++; $display("[TB] FAIL bp_hold: cycle %0d got v=%b d=%h i=%b l=%b expected 1/3/0/0",
                                  c, outValid, outData, outIdx, outLast);
            end
            checks++;
            if (inReady !== 1'b0) begin
               errors++; $display("[TB] FAIL bp_in_ready: cycle %0d got %b expected 0", c, inReady);
            end
         end
      end
      checks++;
      if (sb.size() != 0 || !sent) begin
         errors++; $display("[TB] FAIL bp_drain: got %0d pending expected 0", sb.size());
      end
   endtask

   task automatic test_reset_midword();
      bit seenNew = 0;
      beat_t exp;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         rst = 1'b0; inValid = 1'b0; inData = 8'h00; outReady = 1'b1;
         case (c)
            0: begin inValid = 1'b1; inData = 8'hF0; end
            2: begin rst = 1'b1; inValid = 1'b1; inData = 8'hEE; end
            3: begin inValid = 1'b1; inData = 8'h12; outReady = 1'b0; end
            default: ;
         endcase
         @(negedge clk);
         if (c == 2) begin
            checks++;
            if (inReady !== 1'b0) begin
               errors++; $display("[TB] FAIL midrst_in_ready: got %b expected 0", inReady);
            end
            sb.delete();
         end
         if (c == 3) begin
            checks++;
            if (outValid !== 1'b0) begin
               errors++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", outValid);
            end
         end
         if (inValid && inReady && !rst) pushMain(inData);
         if (outValid && outReady && !rst) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("[TB] FAIL midrst_beat: got unexpected lane %h idx %0d", outData, outIdx);
            end else begin
               exp = sb.pop_front();
               if (c >= 4 && !seenNew && {outData, outIdx} !== {4'h2, 1'b0}) begin
                  errors++; $display("[TB] FAIL midrst_first_lane: got %h/%0d expected 2/0", outData, outIdx);
               end else if ({outData, outIdx, outLast} !== {exp.data[3:0], exp.idx[0], exp.last}) begin
                  errors++; $display("[TB] FAIL midrst_beat: got %h/%0d/%b expected %h/%0d/%b",
                                     outData, outIdx, outLast, exp.data[3:0], exp.idx[0], exp.last);
               end
               if (c >= 4) seenNew = 1;
            end
         end
      end
      checks++;
      if (sb.size() != 0 || !seenNew) begin
         errors++; $display("[TB] FAIL midrst_drain: got %0d pending seen=%0d expected 0 pending seen=1",
                            sb.size(), seenNew);
      end
   endtask

   task automatic test_sweep_one_lane();
      int pushed = 0, beats = 0, cyc = 0;
      beat_t exp;
      while (cyc < 40000 && !(pushed >= 10000 && sb1.size() == 0)) begin
         @(posedge clk); #1;
         cyc++;
         inValid1  = (pushed < 10000) && ($urandom_range(0, 3) != 0);
         inData1   = 8'($urandom);
         outReady1 = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (inValid1 && inReady1) begin push1(inData1); pushed++; end
         if (outValid1 && outReady1) begin
            beats++;
            checks++;
            if (sb1.size() == 0) begin
               errors++; $display("[TB] FAIL sweep1_beat: got unexpected lane %h", outData1);
            end else begin
               exp = sb1.pop_front();
               if ({outData1, outIdx1, outLast1} !== {exp.data, 1'b0, exp.last}) begin
                  errors++; $display("[TB] FAIL sweep1_beat: got %h/%0d/%b expected %h/0/%b",
                                     outData1, outIdx1, outLast1, exp.data, exp.last);
               end
            end
         end
      end
      @(posedge clk); #1;
      inValid1 = 1'b0; outReady1 = 1'b1;
      @(negedge clk);
      checks++;
      if (beats < 10000 || beats != pushed || sb1.size() != 0 || outValid1 !== 1'b0) begin
         errors++; $display("[TB] FAIL sweep1_totals: got beats=%0d pushed=%0d pending=%0d v=%b expected beats=pushed>=10000 pending=0 v=0",
                            beats, pushed, sb1.size(), outValid1);
      end
   endtask

   task automatic test_sweep_four_lanes();
      int pushed = 0, beats = 0, cyc = 0;
      beat_t exp;
      while (cyc < 40000 && !(pushed >= 10000 && sb4.size() == 0)) begin
         @(posedge clk); #1;
         cyc++;
         inValid4  = (pushed < 10000) && ($urandom_range(0, 3) != 0);
         inData4   = 12'($urandom);
         outReady4 = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (inValid4 && inReady4) begin push4(inData4); pushed += 4; end
         if (outValid4 && outReady4) begin
            beats++;
            checks++;
            if (sb4.size() == 0) begin
               errors++; $display("[TB] FAIL sweep4_beat: got unexpected lane %h idx %0d", outData4, outIdx4);
            end else begin
               exp = sb4.pop_front();
               if ({outData4, outIdx4, outLast4} !== {exp.data[2:0], exp.idx, exp.last}) begin
                  errors++; $display("[TB] FAIL sweep4_beat: got %h/%0d/%b expected %h/%0d/%b",
                                     outData4, outIdx4, outLast4, exp.data[2:0], exp.idx, exp.last);
               end
            end
         end
      end
      @(posedge clk); #1;
      inValid4 = 1'b0; outReady4 = 1'b1;
      @(negedge clk);
      checks++;
      if (beats < 10000 || beats != pushed || sb4.size() != 0 || outValid4 !== 1'b0) begin
         errors++; $display("[TB] FAIL sweep4_totals: got beats=%0d pushed=%0d pending=%0d v=%b expected beats=pushed>=10000 pending=0 v=0",
                            beats, pushed, sb4.size(), outValid4);
      end
   endtask

   initial begin
      rst = 1'b1;
      inValid = 1'b0;  inData = '0;  outReady = 1'b0;
      inValid1 = 1'b0; inData1 = '0; outReady1 = 1'b0;
      inValid4 = 1'b0; inData4 = '0; outReady4 = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_reset_midword();
      test_sweep_one_lane();
      test_sweep_four_lanes();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
